btn_event_encoder: RTL

//  Input-side counterpart of the seven-segment output path: turns raw, bouncy push-buttons into

---
 rtl/btn_event_encoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/btn_event_encoder.sv
// ----------------------------------------------------------------------------
// btn_event_encoder
//
// Turns raw, bouncy push-buttons into clean single-cycle step events for the
// counter, all on one system clock. Each button is synchronised, debounced,
// edge-detected for presses and optionally auto-repeated while held. The
// requests are priority-encoded into a one-hot value and offered through a
// valid/ready handshake.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous, active-high; clears all state
//   btn          raw button levels (1 = pressed), asynchronous to clk
//   repeat_en    1 = auto-repeat enabled for the held button
//   evt_ready    consumer takes the event when evt_valid && evt_ready
//   evt_valid    an event is pending
//   evt_value    one-hot step value, bit i = button i; 0 when not valid
//   btn_state    debounced button levels
//   evt_dropped  sticky flag: an event was lost (cleared only by reset)
// ----------------------------------------------------------------------------
module btn_event_encoder #(
    parameter int NUM_BTN       = 4,
    parameter int DEBOUNCE_CYC  = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               repeat_en,
    input  logic               evt_ready,
    output logic               evt_valid,
    output logic [NUM_BTN-1:0] evt_value,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_dropped
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int IDX_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } rptState_t;

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [DB_W-1:0]    r_dbCnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_btnState;
    logic [NUM_BTN-1:0] r_btnPrev;

    rptState_t          r_state;
    logic [IDX_W-1:0]   r_trkIdx;
    logic [RPT_W-1:0]   r_rptCnt;

    logic               r_evtValid;
    logic [NUM_BTN-1:0] r_evtValue;
    logic               r_evtDropped;

    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_pressOneHot;
    logic [IDX_W-1:0]   w_pressIdx;
    logic [NUM_BTN-1:0] w_trkOneHot;
    logic               w_anyPress;
    logic               w_multiPress;
    logic               w_rptReq;
    logic               w_req;
    logic [NUM_BTN-1:0] w_reqValue;
    logic               w_blocked;
    logic               w_conflict;

    // Two-flop synchroniser; only the first stage ever sees the raw pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive cycles where the synchronised level
    // disagrees with the accepted level; any agreement restarts the count.
    // r_btnPrev keeps last cycle's accepted level for press detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btnState <= '0;
            r_btnPrev  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_btnPrev <= r_btnState;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_sync2[i] != r_btnState[i]) begin
                    if (r_dbCnt[i] == DB_LAST) begin
                        r_btnState[i] <= ~r_btnState[i];
                        r_dbCnt[i]    <= '0;
                    end else begin
                        r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
                    end
                end else begin
                    r_dbCnt[i] <= '0;
                end
            end
        end
    end

    // Press requests and their priority encoding (lowest index wins).
    assign w_press       = r_btnState & ~r_btnPrev;
    assign w_pressOneHot = w_press & (~w_press + NUM_BTN'(1));
    assign w_anyPress    = |w_press;
    assign w_multiPress  = |(w_press & ~w_pressOneHot);

    always_comb begin
        w_pressIdx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_pressIdx = IDX_W'(i);
            end
        end
    end

    // A repeat fires when the tracked button is still down, repeats are
    // enabled and the hold counter has reached the current phase's limit.
    assign w_trkOneHot = NUM_BTN'(1) << r_trkIdx;
    assign w_rptReq    = repeat_en && r_btnState[r_trkIdx] &&
                         (((r_state == S_HOLD)   && (r_rptCnt == DELAY_LAST)) ||
                          ((r_state == S_REPEAT) && (r_rptCnt == PERIOD_LAST)));

    // A fresh press outranks a repeat of the old button in the same cycle.
    assign w_req      = w_anyPress | w_rptReq;
    assign w_reqValue = w_anyPress ? w_pressOneHot : (w_rptReq ? w_trkOneHot : '0);
    assign w_blocked  = r_evtValid & ~evt_ready;
    assign w_conflict = w_multiPress | (w_anyPress & w_rptReq);

    // Repeat tracker. Any press retargets it to the winning button and
    // restarts the hold time; with repeats disabled the count is frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_trkIdx <= '0;
            r_rptCnt <= '0;
        end else if (w_anyPress) begin
            r_trkIdx <= w_pressIdx;
            r_rptCnt <= '0;
            r_state  <= S_HOLD;
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                default: begin
                    if (!r_btnState[r_trkIdx]) begin
                        r_state  <= S_IDLE;
                        r_rptCnt <= '0;
                    end else if (repeat_en) begin
                        if (w_rptReq) begin
                            r_rptCnt <= '0;
                            r_state  <= S_REPEAT;
                        end else begin
                            r_rptCnt <= r_rptCnt + RPT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Output register: a consumed slot may be refilled in the same cycle;
    // a request that finds the slot still occupied is lost and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evtValid   <= 1'b0;
            r_evtValue   <= '0;
            r_evtDropped <= 1'b0;
        end else begin
            if (w_req && !w_blocked) begin
                r_evtValid <= 1'b1;
                r_evtValue <= w_reqValue;
            end else if (r_evtValid && evt_ready) begin
                r_evtValid <= 1'b0;
                r_evtValue <= '0;
            end
            if (w_conflict || (w_req && w_blocked)) begin
                r_evtDropped <= 1'b1;
            end
        end
    end

    assign evt_valid   = r_evtValid;
    assign evt_value   = r_evtValue;
    assign btn_state   = r_btnState;
    assign evt_dropped = r_evtDropped;

endmodule
